// File: rtl/delayprog_pkg.sv
// delayprog_pkg: shared types and default sizes for the programmable edge-delay block.
package delayprog_pkg;
    typedef enum logic [1:0] {MODE_RISE = 2'b00, MODE_FALL = 2'b01, MODE_BOTH = 2'b10, MODE_NONE = 2'b11} mode_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;
    localparam int CW_DEF  = 8;
    localparam int NCH_DEF = 4;
endpackage

// File: rtl/delayprog_chan.sv
// delayprog_chan: one channel; delays qualifying edges by dly cycles and filters reverting inputs.
module delayprog_chan
    import delayprog_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_en,
    input  mode_t         i_mode,
    input  logic [CW-1:0] i_dly,
    input  logic          i_in,
    output logic          o_out,
    output logic          o_busy
);
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_out, w_out, r_busy, w_busy;
    logic          w_diff, w_qual;

    assign w_diff = i_in != r_out;
    assign w_qual = (i_mode == MODE_RISE && !r_out && i_in) ||
                    (i_mode == MODE_FALL && r_out && !i_in) ||
                    (i_mode == MODE_BOTH && w_diff);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_out   = r_out;
        w_busy  = r_busy;
        if (!i_en) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_out   = i_in;
            w_busy  = 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_diff && w_qual && i_dly >= CW'(2)) begin
                w_cnt   = i_dly - CW'(1);
                w_state = ST_COUNT;
                w_busy  = 1'b1;
            end else if (w_diff) begin
                w_out = i_in;
            end
        end else if (!w_diff || r_cnt == CW'(1)) begin
            // a reverted input leaves o untouched, so glitches shorter than dly vanish
            w_out   = i_in;
            w_state = ST_IDLE;
            w_busy  = 1'b0;
        end else begin
            w_cnt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_out   <= w_out;
            r_busy  <= w_busy;
        end
    end

    assign o_out  = r_out;
    assign o_busy = r_busy;
endmodule

// File: rtl/delayprog_multi.sv
// delayprog_multi: NCH independent programmable edge-delay channels sharing mode and delay.
// Supply pins are kept only for netlist compatibility.
module delayprog_multi
    import delayprog_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           CELCLK,
    input  logic           CELRSTN,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           CELSUB,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [CW-1:0]  dly,
    input  logic [NCH-1:0] i,
    output logic [NCH-1:0] o,
    output logic [NCH-1:0] busy
);
    logic w_unused;

    assign w_unused = &{CELV, CELG, CELSUB, 1'b0};

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        delayprog_chan #(.CW(CW)) u_chan (
            .i_clk  (CELCLK),
            .i_rstn (CELRSTN),
            .i_en   (en),
            .i_mode (mode_t'(mode)),
            .i_dly  (dly),
            .i_in   (i[n]),
            .o_out  (o[n]),
            .o_busy (busy[n])
        );
    end
endmodule

// File: tb/tb_delayprog_multi.sv
// tb_delayprog_multi: directed scenarios with hand-computed edge timing.
module tb_delayprog_multi;
    logic       CELCLK = 1'b0, CELRSTN = 1'b0, CELV = 1'b1, CELG = 1'b0, CELSUB = 1'b0;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] dly = 8'd0;
    logic [3:0] i = 4'b0000;
    logic [3:0] o, busy;
    int         n_checks = 0, n_fail = 0;

    delayprog_multi #(.NCH(4), .CW(8)) dut (
        .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .CELSUB(CELSUB),
        .en(en), .mode(mode), .dly(dly), .i(i), .o(o), .busy(busy)
    );

    always #5 CELCLK = ~CELCLK;

    task automatic tick();
        @(posedge CELCLK);
        #1;
    endtask

    task automatic settle();
        mode = 2'b11;
        i = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        CELRSTN = 1'b0;
        tick();
        n_checks++;
        if (o !== 4'b0000 || busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_init o=%b busy=%b want o=0000 busy=0000", o, busy);
        end
        CELRSTN = 1'b1;
        mode = 2'b00;
        dly = 8'd10;
        i = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (busy !== 4'b0001 || o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pending o=%b busy=%b want o=0000 busy=0001", o, busy);
        end
        CELRSTN = 1'b0;
        tick();
        n_checks++;
        if (o !== 4'b0000 || busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midcount o=%b busy=%b want o=0000 busy=0000", o, busy);
        end
        i = 4'b0000;
        CELRSTN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (o !== 4'b0000 || busy !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_after k=%0d o=%b busy=%b want 0000/0000", k, o, busy);
            end
        end
    endtask

    task automatic test_rise();
        mode = 2'b00;
        dly = 8'd5;
        i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (busy[0] !== 1'b1 || o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rise_count t0+%0d o0=%b busy0=%b want o0=0 busy0=1", k, o[0], busy[0]);
            end
        end
        tick();
        n_checks++;
        if (o[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_out o0=%b busy0=%b want o0=1 busy0=0", o[0], busy[0]);
        end
        i[0] = 1'b0;
        tick();
        n_checks++;
        if (o[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_fallpass o0=%b busy0=%b want o0=0 busy0=0", o[0], busy[0]);
        end
    endtask

    task automatic test_glitch();
        mode = 2'b10;
        dly = 8'd4;
        i[1] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy[1] !== 1'b1 || o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy o1=%b busy1=%b want o1=0 busy1=1", o[1], busy[1]);
        end
        i[1] = 1'b0;
        tick();
        n_checks++;
        if (busy[1] !== 1'b0 || o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_revert o1=%b busy1=%b want o1=0 busy1=0", o[1], busy[1]);
        end
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_later o1=%b want 0", o[1]);
        end
        mode = 2'b00;
        dly = 8'd3;
        i[0] = 1'b1;
        tick();
        tick();
        i[0] = 1'b0;
        tick();
        n_checks++;
        if (o[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL revert_at_expiry o0=%b busy0=%b want o0=0 busy0=0", o[0], busy[0]);
        end
    endtask

    task automatic test_short_delay();
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 4; m++) begin
                dly = 8'(d);
                mode = 2'(m);
                i = 4'b1111;
                tick();
                n_checks++;
                if (o !== 4'b1111 || busy !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL short_up dly=%0d mode=%0d o=%b busy=%b want 1111/0000", d, m, o, busy);
                end
                i = 4'b0000;
                tick();
                n_checks++;
                if (o !== 4'b0000 || busy !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL short_dn dly=%0d mode=%0d o=%b busy=%b want 0000/0000", d, m, o, busy);
                end
            end
        end
    endtask

    task automatic test_dly_change();
        mode = 2'b00;
        dly = 8'd8;
        i[2] = 1'b1;
        tick();
        for (int k = 1; k < 7; k++) begin
            if (k == 3) dly = 8'd2;
            tick();
            n_checks++;
            if (o[2] !== 1'b0 || busy[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL dlychg_hold t0+%0d o2=%b busy2=%b want o2=0 busy2=1", k, o[2], busy[2]);
            end
        end
        tick();
        n_checks++;
        if (o[2] !== 1'b1 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL dlychg_out o2=%b busy2=%b want o2=1 busy2=0", o[2], busy[2]);
        end
    endtask

    task automatic test_all_channels();
        mode = 2'b01;
        dly = 8'd3;
        i = 4'b1111;
        tick();
        n_checks++;
        if (o !== 4'b1111 || busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL allch_rise o=%b busy=%b want 1111/0000", o, busy);
        end
        i = 4'b1010;
        tick();
        n_checks++;
        if (o !== 4'b1111 || busy !== 4'b0101) begin
            n_fail++;
            $display("FAIL allch_t0 o=%b busy=%b want 1111/0101", o, busy);
        end
        tick();
        tick();
        n_checks++;
        if (o !== 4'b1010 || busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL allch_out o=%b busy=%b want 1010/0000", o, busy);
        end
    endtask

    task automatic test_enable();
        mode = 2'b00;
        dly = 8'd6;
        i[3] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy[3] !== 1'b1 || o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_pending o3=%b busy3=%b want o3=0 busy3=1", o[3], busy[3]);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (o[3] !== 1'b1 || busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop o3=%b busy3=%b want o3=1 busy3=0", o[3], busy[3]);
        end
        i[3] = 1'b0;
        tick();
        n_checks++;
        if (o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_bypass_dn o3=%b want 0", o[3]);
        end
        i[3] = 1'b1;
        tick();
        n_checks++;
        if (o[3] !== 1'b1 || busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_bypass_up o3=%b busy3=%b want o3=1 busy3=0", o[3], busy[3]);
        end
        i[3] = 1'b0;
        tick();
        en = 1'b1;
        tick();
        i[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (o[3] !== 1'b0 || busy[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL en_reenable t0+%0d o3=%b busy3=%b want o3=0 busy3=1", k, o[3], busy[3]);
            end
        end
        tick();
        n_checks++;
        if (o[3] !== 1'b1 || busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_reenable_out o3=%b busy3=%b want o3=1 busy3=0", o[3], busy[3]);
        end
    endtask

    initial begin
        test_reset();
        settle();
        test_rise();
        settle();
        test_glitch();
        settle();
        test_short_delay();
        settle();
        test_dly_change();
        settle();
        test_all_channels();
        settle();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/delayprog_multi.md
# delayprog_multi

Parametrised, programmable multi-channel edge-delay block: the clocked successor to the fixed 10 ns rise-edge delay cell. Each of NCH channels delays qualifying input transitions by a programmable number of clock cycles. The edge mode is selectable: rise, fall, both or none. An input that reverts before its delay expires is filtered and never reaches the output. The block sits in the loop control path in place of fixed delay cells, and keeps the CELV/CELG/CELSUB supply pins for netlist compatibility.

## Interface
- NCH, 4: number of independent channels.
- CW, 8: delay counter width; maximum delay 2^CW−1 cycles.
- CELCLK  in  1  single clock; all state updates on the rising edge.
- CELRSTN  in  1  reset, synchronous, active-low.
- CELV  in  1  supply pin; no logic function.
- CELG  in  1  ground pin; no logic function.
- CELSUB  in  1  substrate pin; no logic function.
- en  in  1  enable; low forces bypass.
- mode  in  2  edge mode: 00 rise, 01 fall, 10 both, 11 none.
- dly  in  CW  delay in cycles, shared by all channels.
- i  in  NCH  channel inputs, synchronous to CELCLK.
- o  out  NCH  delayed outputs, registered.
- busy  out  NCH  channel n is counting a pending transition, registered.

## Operation
- Per-channel FSM with two states, IDLE and COUNT, plus a CW-bit counter cnt.
- IDLE, sampled i[n]==o[n]: no action.
- IDLE, i[n]!=o[n], transition not qualifying (direction not selected by mode, mode=11, or dly≤1): o[n]<=i[n] on this edge; stay in IDLE.
- IDLE, i[n]!=o[n], qualifying and dly≥2: cnt<=dly−1; state<=COUNT; busy[n]<=1.
- Qualification: rise means o=0 and i=1; fall means o=1 and i=0; both accepts either direction.
- COUNT, i[n]==o[n] (input reverted): cancel; state<=IDLE; busy<=0; o unchanged. This filters glitches shorter than dly cycles.
- COUNT, i[n]!=o[n], cnt==1: o[n]<=i[n]; state<=IDLE; busy<=0.
- COUNT, otherwise: cnt<=cnt−1.
- dly and mode are sampled only at COUNT entry. Changes during COUNT do not affect in-flight transitions.
- en=0 overrides both states: state<=IDLE, cnt<=0, busy<=0, o[n]<=i[n] on every edge.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Reset (CELRSTN=0 at an edge): o=0, busy=0, cnt=0, state=IDLE. Reset takes priority over en and any in-flight count; a pending transition is discarded.
- Let edge t0 be the first edge that samples the new i. Define L = the edge at which o updates, counting t0 as edge 1.
- Non-qualifying transition, dly∈{0,1}, or en=0: L=1, so o changes at t0.
- Qualifying transition: L=dly, so o changes at edge t0+dly−1.
- busy rises at t0 and falls at the same edge o updates, or at the cancel edge.
- Maximum delay 2^CW−1 cycles; cnt never wraps, because load is dly−1 ≥1 and COUNT exits at cnt==1.
- Input reverting at exactly edge t0+dly−1: the reversion is seen as i==o at that edge, so the transition is cancelled and o stays unchanged.
- Re-toggle after a cancel: treated as a fresh transition; the counter reloads from the current dly.

## Structure
- Package delayprog_pkg:
  - mode_t enum: MODE_RISE, MODE_FALL, MODE_BOTH, MODE_NONE.
  - state_t enum: ST_IDLE, ST_COUNT.
  - Default constants for CW and NCH.
- Sub-module delayprog_chan: one channel FSM plus counter, parameter CW, instantiated NCH times by a generate loop in delayprog_multi.
- Supply pins are ports of the top level only and are not routed into delayprog_chan.

## Test plan
- Reset with CELRSTN low mid-count (dly=10, rise pending 5 cycles): o=0 and busy=0 after the edge; no later output change.
- mode=00, dly=5, i[0] 0→1 and held: busy[0]=1 for edges t0..t0+3; o[0]=1 at edge t0+4; a later 1→0 fall passes with L=1.
- mode=10, dly=4, i[1] high for 2 cycles then low: o[1] stays 0 (glitch filtered); busy[1] drops at the revert edge.
- dly=0 and dly=1, any mode: every transition appears at o with L=1; busy stays 0.
- dly changed from 8 to 2 three cycles into a count: o still updates at t0+7. All four channels toggled on the same edge with mode=01: independent outputs.
- en dropped mid-count, then raised: o follows i with L=1 while en=0; after re-enable, a fresh qualifying edge produces L=dly.
